// File: rtl/tl_ul_pkg.sv
// rtl/tl_ul_pkg.sv - shared TL-UL opcodes, arbiter state and beat-count helper
package tl_ul_pkg;

  // Channel A opcodes
  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;

  // Channel D opcodes
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  // Beat counters hold beats-1; the largest legal burst (size 6) is 16 beats
  localparam int BEAT_W = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Beats carried by a request of the given size on a 4-byte bus.
  // Illegal sizes (above 6) are treated as one beat so they never lock the channel.
  function automatic logic [4:0] beats_from_size(input logic [3:0] size);
    if (size <= 4'd2 || size > 4'd6) begin
      return 5'd1;
    end
    return 5'd1 << (size - 4'd2);
  endfunction

  function automatic logic is_put(input logic [2:0] opcode);
    return (opcode == OP_PUT_FULL) || (opcode == OP_PUT_PARTIAL);
  endfunction

endpackage

// File: rtl/tl_ul_rr_arb2.sv
// rtl/tl_ul_rr_arb2.sv - two-way round-robin pointer and grant selection
module tl_ul_rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_idx,
  output logic       grant_any,
  output logic       grant_idx
);

  logic last_grant;

  // Pointer moves to the master whose request just completed its last A beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= upd_idx;
    end
  end

  // Single requester wins outright; on contention the master not served last wins
  always_comb begin
    grant_any = |req;
    grant_idx = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/tl_ul_arb2.sv
// rtl/tl_ul_arb2.sv - two-master TL-UL arbiter with burst lock and outstanding tracking
module tl_ul_arb2
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 1,
  parameter int MAX_OUT = 2
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              m0_a_valid,
  input  logic [2:0]        m0_a_opcode,
  input  logic [2:0]        m0_a_param,
  input  logic [3:0]        m0_a_size,
  input  logic [SRC_W-1:0]  m0_a_source,
  input  logic [ADDR_W-1:0] m0_a_address,
  input  logic [3:0]        m0_a_mask,
  input  logic [DATA_W-1:0] m0_a_data,
  output logic              m0_a_ready,

  input  logic              m1_a_valid,
  input  logic [2:0]        m1_a_opcode,
  input  logic [2:0]        m1_a_param,
  input  logic [3:0]        m1_a_size,
  input  logic [SRC_W-1:0]  m1_a_source,
  input  logic [ADDR_W-1:0] m1_a_address,
  input  logic [3:0]        m1_a_mask,
  input  logic [DATA_W-1:0] m1_a_data,
  output logic              m1_a_ready,

  output logic              s_a_valid,
  output logic [2:0]        s_a_opcode,
  output logic [2:0]        s_a_param,
  output logic [3:0]        s_a_size,
  output logic [SRC_W:0]    s_a_source,
  output logic [ADDR_W-1:0] s_a_address,
  output logic [3:0]        s_a_mask,
  output logic [DATA_W-1:0] s_a_data,
  input  logic              s_a_ready,

  input  logic              s_d_valid,
  input  logic [2:0]        s_d_opcode,
  input  logic [1:0]        s_d_param,
  input  logic [3:0]        s_d_size,
  input  logic [SRC_W:0]    s_d_source,
  input  logic              s_d_denied,
  input  logic [DATA_W-1:0] s_d_data,
  output logic              s_d_ready,

  output logic              m0_d_valid,
  output logic [2:0]        m0_d_opcode,
  output logic [1:0]        m0_d_param,
  output logic [3:0]        m0_d_size,
  output logic [SRC_W-1:0]  m0_d_source,
  output logic              m0_d_denied,
  output logic [DATA_W-1:0] m0_d_data,
  input  logic              m0_d_ready,

  output logic              m1_d_valid,
  output logic [2:0]        m1_d_opcode,
  output logic [1:0]        m1_d_param,
  output logic [3:0]        m1_d_size,
  output logic [SRC_W-1:0]  m1_d_source,
  output logic              m1_d_denied,
  output logic [DATA_W-1:0] m1_d_data,
  input  logic              m1_d_ready,

  output logic              err_unexpected_d
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  arb_state_e            state;
  logic [BEAT_W-1:0]     a_beat_cnt;
  logic [BEAT_W-1:0]     d_beat_cnt;
  logic                  lock_idx;
  logic [1:0][OUT_W-1:0] outstanding;

  logic [1:0] eligible;
  logic [1:0] arb_req;
  logic       arb_any;
  logic       arb_idx;
  logic       grant_any;
  logic       grant_idx;

  logic       a_hs;
  logic [4:0] a_beats;
  logic       a_multi;
  logic       a_first;
  logic       a_last;

  logic       d_idx;
  logic       d_hs;
  logic [4:0] d_beats;
  logic       d_last;

  logic [1:0] out_inc;
  logic [1:0] out_dec;
  logic [1:0] out_nz;

  // A master may compete only while it has room for another outstanding request
  always_comb begin
    eligible[0] = m0_a_valid && (outstanding[0] < MAX_OUT_C);
    eligible[1] = m1_a_valid && (outstanding[1] < MAX_OUT_C);
    arb_req     = (state == ST_IDLE) ? eligible : 2'b00;
  end

  tl_ul_rr_arb2 u_rr (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (arb_req),
    .update    (a_last),
    .upd_idx   (grant_idx),
    .grant_any (arb_any),
    .grant_idx (arb_idx)
  );

  // During a burst the grant is pinned to the burst owner regardless of eligibility
  always_comb begin
    grant_any = (state == ST_LOCKED) || arb_any;
    grant_idx = (state == ST_LOCKED) ? lock_idx : arb_idx;
  end

  // Zero-latency A mux; everything handshake-related is forced low in reset
  always_comb begin
    s_a_opcode  = grant_idx ? m1_a_opcode  : m0_a_opcode;
    s_a_param   = grant_idx ? m1_a_param   : m0_a_param;
    s_a_size    = grant_idx ? m1_a_size    : m0_a_size;
    s_a_source  = {grant_idx, (grant_idx ? m1_a_source : m0_a_source)};
    s_a_address = grant_idx ? m1_a_address : m0_a_address;
    s_a_mask    = grant_idx ? m1_a_mask    : m0_a_mask;
    s_a_data    = grant_idx ? m1_a_data    : m0_a_data;
    s_a_valid   = reset_n && grant_any && (grant_idx ? m1_a_valid : m0_a_valid);
    m0_a_ready  = reset_n && grant_any && !grant_idx && s_a_ready;
    m1_a_ready  = reset_n && grant_any &&  grant_idx && s_a_ready;
  end

  // Classify the current A beat: first beat, multi-beat Put, last beat
  always_comb begin
    a_hs    = s_a_valid && s_a_ready;
    a_beats = beats_from_size(s_a_size);
    a_multi = is_put(s_a_opcode) && (a_beats > 5'd1);
    a_first = a_hs && (state == ST_IDLE);
    a_last  = a_hs && (((state == ST_IDLE) && !a_multi) ||
                       ((state == ST_LOCKED) && (a_beat_cnt == BEAT_W'(1))));
  end

  // Burst lock FSM: a multi-beat Put holds the channel until its last beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      a_beat_cnt <= '0;
      lock_idx   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (a_first && a_multi) begin
            state      <= ST_LOCKED;
            a_beat_cnt <= BEAT_W'(a_beats - 5'd1);
            lock_idx   <= grant_idx;
          end
        end
        ST_LOCKED: begin
          if (a_hs) begin
            a_beat_cnt <= a_beat_cnt - BEAT_W'(1);
            if (a_beat_cnt == BEAT_W'(1)) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // D routing by the top source bit; payload is broadcast, only valid is steered
  always_comb begin
    d_idx       = s_d_source[SRC_W];
    m0_d_valid  = reset_n && s_d_valid && !d_idx;
    m1_d_valid  = reset_n && s_d_valid &&  d_idx;
    s_d_ready   = reset_n && (d_idx ? m1_d_ready : m0_d_ready);
    m0_d_opcode = s_d_opcode;
    m0_d_param  = s_d_param;
    m0_d_size   = s_d_size;
    m0_d_source = s_d_source[SRC_W-1:0];
    m0_d_denied = s_d_denied;
    m0_d_data   = s_d_data;
    m1_d_opcode = s_d_opcode;
    m1_d_param  = s_d_param;
    m1_d_size   = s_d_size;
    m1_d_source = s_d_source[SRC_W-1:0];
    m1_d_denied = s_d_denied;
    m1_d_data   = s_d_data;
  end

  // Only AccessAckData spans several beats; AccessAck is always one
  always_comb begin
    d_hs    = s_d_valid && s_d_ready;
    d_beats = (s_d_opcode == OP_ACCESS_ACK_DATA) ? beats_from_size(s_d_size) : 5'd1;
    if (d_beat_cnt == '0) begin
      d_last = d_hs && (d_beats == 5'd1);
    end else begin
      d_last = d_hs && (d_beat_cnt == BEAT_W'(1));
    end
  end

  // D beat counter: loaded on the first beat of a response, counts down to its last
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_beat_cnt <= '0;
    end else if (d_hs) begin
      if (d_beat_cnt == '0) begin
        d_beat_cnt <= BEAT_W'(d_beats - 5'd1);
      end else begin
        d_beat_cnt <= d_beat_cnt - BEAT_W'(1);
      end
    end
  end

  // Per-master increment on request accept, decrement on response completion
  always_comb begin
    out_inc   = {a_first &&  grant_idx, a_first && !grant_idx};
    out_dec   = {d_last  &&  d_idx,     d_last  && !d_idx};
    out_nz[0] = (outstanding[0] != '0);
    out_nz[1] = (outstanding[1] != '0);
  end

  // Outstanding counters never underflow; a response with nothing pending raises the sticky flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding      <= '0;
      err_unexpected_d <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (out_inc[i] && !out_dec[i]) begin
          outstanding[i] <= outstanding[i] + OUT_W'(1);
        end else if (out_dec[i] && !out_inc[i] && out_nz[i]) begin
          outstanding[i] <= outstanding[i] - OUT_W'(1);
        end
      end
      if (|(out_dec & ~out_nz)) begin
        err_unexpected_d <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tl_ul_arb2.sv
// tb/tb_tl_ul_arb2.sv - directed and randomized self-checking bench for tl_ul_arb2
module tb_tl_ul_arb2;

  localparam logic [2:0] GET  = 3'd4;
  localparam logic [2:0] PUTF = 3'd0;
  localparam logic [2:0] PUTP = 3'd1;
  localparam int MAXO = 2;

  logic clock;
  logic reset_n;

  logic [1:0]        a_valid;
  logic [1:0][2:0]   a_opcode;
  logic [1:0][2:0]   a_param;
  logic [1:0][3:0]   a_size;
  logic [1:0]        a_source;
  logic [1:0][31:0]  a_address;
  logic [1:0][3:0]   a_mask;
  logic [1:0][31:0]  a_data;
  logic              m0_a_ready, m1_a_ready;

  logic        s_a_valid;
  logic [2:0]  s_a_opcode, s_a_param;
  logic [3:0]  s_a_size;
  logic [1:0]  s_a_source;
  logic [31:0] s_a_address;
  logic [3:0]  s_a_mask;
  logic [31:0] s_a_data;
  logic        s_a_ready;

  logic        s_d_valid;
  logic [2:0]  s_d_opcode;
  logic [1:0]  s_d_param;
  logic [3:0]  s_d_size;
  logic [1:0]  s_d_source;
  logic        s_d_denied;
  logic [31:0] s_d_data;
  logic        s_d_ready;

  logic        m0_d_valid, m1_d_valid;
  logic [2:0]  m0_d_opcode, m1_d_opcode;
  logic [1:0]  m0_d_param, m1_d_param;
  logic [3:0]  m0_d_size, m1_d_size;
  logic        m0_d_source, m1_d_source;
  logic        m0_d_denied, m1_d_denied;
  logic [31:0] m0_d_data, m1_d_data;
  logic [1:0]  d_ready;
  logic        err_unexpected_d;

  int n_cmp = 0;
  int n_bad = 0;

  tl_ul_arb2 dut (
    .clock(clock), .reset_n(reset_n),
    .m0_a_valid(a_valid[0]), .m0_a_opcode(a_opcode[0]), .m0_a_param(a_param[0]),
    .m0_a_size(a_size[0]), .m0_a_source(a_source[0]), .m0_a_address(a_address[0]),
    .m0_a_mask(a_mask[0]), .m0_a_data(a_data[0]), .m0_a_ready(m0_a_ready),
    .m1_a_valid(a_valid[1]), .m1_a_opcode(a_opcode[1]), .m1_a_param(a_param[1]),
    .m1_a_size(a_size[1]), .m1_a_source(a_source[1]), .m1_a_address(a_address[1]),
    .m1_a_mask(a_mask[1]), .m1_a_data(a_data[1]), .m1_a_ready(m1_a_ready),
    .s_a_valid(s_a_valid), .s_a_opcode(s_a_opcode), .s_a_param(s_a_param),
    .s_a_size(s_a_size), .s_a_source(s_a_source), .s_a_address(s_a_address),
    .s_a_mask(s_a_mask), .s_a_data(s_a_data), .s_a_ready(s_a_ready),
    .s_d_valid(s_d_valid), .s_d_opcode(s_d_opcode), .s_d_param(s_d_param),
    .s_d_size(s_d_size), .s_d_source(s_d_source), .s_d_denied(s_d_denied),
    .s_d_data(s_d_data), .s_d_ready(s_d_ready),
    .m0_d_valid(m0_d_valid), .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param),
    .m0_d_size(m0_d_size), .m0_d_source(m0_d_source), .m0_d_denied(m0_d_denied),
    .m0_d_data(m0_d_data), .m0_d_ready(d_ready[0]),
    .m1_d_valid(m1_d_valid), .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param),
    .m1_d_size(m1_d_size), .m1_d_source(m1_d_source), .m1_d_denied(m1_d_denied),
    .m1_d_data(m1_d_data), .m1_d_ready(d_ready[1]),
    .err_unexpected_d(err_unexpected_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [3:0] sz, input logic [31:0] addr);
    a_valid[i]   = v;
    a_opcode[i]  = op;
    a_size[i]    = sz;
    a_source[i]  = 1'b0;
    a_address[i] = addr;
  endtask

  function automatic int nbeats(input int sz);
    return (sz <= 2) ? 1 : (1 << (sz - 2));
  endfunction

  typedef struct {
    logic [1:0] src;
    logic [2:0] op;
    logic [3:0] size;
  } rsp_t;

  rsp_t q[$];
  rsp_t rsp;
  int   out_m[2];
  int   mb_left[2];
  int   last_g, own, a_rem, g, d_left, nb;
  bit   gany, e0, e1, exp_sav, exp_sdr, a_hs, d_hs, d_on, didx;
  int   r;

  initial begin
    reset_n = 1'b0;
    a_valid = '0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '1; a_data = '0;
    s_a_ready = 1'b1; d_ready = 2'b11;
    s_d_valid = 1'b1; s_d_opcode = 3'd0; s_d_param = 2'd0; s_d_size = 4'd2;
    s_d_source = 2'b00; s_d_denied = 1'b0; s_d_data = '0;
    a_valid = 2'b11;
    #1;
    // outputs held quiet while reset is asserted, whatever the inputs
    chk("rst_m0_a_ready", m0_a_ready, 0);
    chk("rst_m1_a_ready", m1_a_ready, 0);
    chk("rst_s_a_valid", s_a_valid, 0);
    chk("rst_m0_d_valid", m0_d_valid, 0);
    chk("rst_m1_d_valid", m1_d_valid, 0);
    chk("rst_err", err_unexpected_d, 0);
    a_valid = 2'b00; s_d_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // both masters Get together: m0 first, then m1
    set_req(0, 1, GET, 2, 32'h100);
    set_req(1, 1, GET, 2, 32'h200);
    #1;
    chk("rr_first_valid", s_a_valid, 1);
    chk("rr_first_src", s_a_source, 2'b00);
    chk("rr_first_addr", s_a_address, 32'h100);
    chk("rr_first_m0_ready", m0_a_ready, 1);
    chk("rr_first_m1_ready", m1_a_ready, 0);
    tick();
    chk("rr_second_src", s_a_source, 2'b10);
    chk("rr_second_addr", s_a_address, 32'h200);
    chk("rr_second_m1_ready", m1_a_ready, 1);
    chk("rr_second_m0_ready", m0_a_ready, 0);
    tick();

    // 4-beat PutFull from m0 holds the channel against a pending m1 Get
    set_req(0, 1, PUTF, 4, 32'h300);
    for (int b = 0; b < 4; b++) begin
      a_data[0] = 32'hA0 + b;
      #1;
      chk("burst_m0_ready", m0_a_ready, 1);
      chk("burst_m1_ready", m1_a_ready, 0);
      chk("burst_src", s_a_source, 2'b00);
      chk("burst_data", s_a_data, 32'hA0 + b);
      tick();
    end
    set_req(0, 1, GET, 2, 32'h400);
    #1;
    chk("after_burst_m1_ready", m1_a_ready, 1);
    chk("after_burst_src", s_a_source, 2'b10);
    chk("m0_full_ready", m0_a_ready, 0);
    tick();
    a_valid[1] = 1'b0;
    #1;
    chk("m0_full_ready2", m0_a_ready, 0);
    chk("m0_full_sav", s_a_valid, 0);
    tick();

    // AccessAck to m0 frees one slot; m0 accepted on the following cycle
    s_d_valid = 1'b1; s_d_opcode = 3'd0; s_d_size = 4'd2; s_d_source = 2'b00;
    #1;
    chk("ack_m0_d_valid", m0_d_valid, 1);
    chk("ack_m1_d_valid", m1_d_valid, 0);
    chk("ack_s_d_ready", s_d_ready, 1);
    chk("ack_same_cycle_ready", m0_a_ready, 0);
    tick();
    s_d_valid = 1'b0;
    #1;
    chk("ack_next_cycle_ready", m0_a_ready, 1);
    chk("ack_next_cycle_addr", s_a_address, 32'h400);
    tick();
    a_valid[0] = 1'b0;

    // 2-beat AccessAckData to m1 with backpressure
    s_d_valid = 1'b1; s_d_opcode = 3'd1; s_d_size = 4'd3; s_d_source = 2'b10;
    s_d_data = 32'hD0; d_ready[1] = 1'b0;
    set_req(1, 1, GET, 2, 32'h500);
    #1;
    chk("aad_m1_d_valid", m1_d_valid, 1);
    chk("aad_m0_d_valid", m0_d_valid, 0);
    chk("aad_m1_d_source", m1_d_source, 0);
    chk("aad_stall_ready", s_d_ready, 0);
    chk("aad_m1_a_ready0", m1_a_ready, 0);
    tick();
    d_ready[1] = 1'b1;
    #1;
    chk("aad_beat1_ready", s_d_ready, 1);
    chk("aad_beat1_data", m1_d_data, 32'hD0);
    chk("aad_m1_a_ready1", m1_a_ready, 0);
    tick();
    s_d_data = 32'hD1;
    #1;
    chk("aad_beat2_valid", m1_d_valid, 1);
    chk("aad_m1_a_ready2", m1_a_ready, 0);
    tick();
    s_d_valid = 1'b0;
    #1;
    chk("aad_done_m1_a_ready", m1_a_ready, 1);
    tick();
    a_valid[1] = 1'b0;

    // drain m0's two requests, then a third ack is unexpected
    for (int k = 0; k < 3; k++) begin
      s_d_valid = 1'b1; s_d_opcode = 3'd0; s_d_size = 4'd2; s_d_source = 2'b00;
      #1;
      chk("drain_m0_d_valid", m0_d_valid, 1);
      tick();
      chk("drain_err", err_unexpected_d, (k == 2) ? 1 : 0);
    end
    s_d_valid = 1'b0;
    set_req(0, 1, GET, 2, 32'h600);
    #1;
    chk("post_err_m0_ready", m0_a_ready, 1);
    tick();
    a_valid[0] = 1'b0;
    tick(); tick(); tick();
    chk("err_sticky", err_unexpected_d, 1);

    // reset in the middle of a 4-beat Put abandons the burst
    set_req(0, 1, PUTF, 4, 32'h700);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_sav", s_a_valid, 0);
    chk("midrst_m0_ready", m0_a_ready, 0);
    chk("midrst_err", err_unexpected_d, 0);
    tick(); tick();
    reset_n = 1'b1;
    set_req(0, 1, GET, 2, 32'h800);
    set_req(1, 1, GET, 2, 32'h900);
    #1;
    chk("postrst_src", s_a_source, 2'b00);
    chk("postrst_m0_ready", m0_a_ready, 1);
    chk("postrst_m1_ready", m1_a_ready, 0);
    tick();
    chk("postrst_m1_next", m1_a_ready, 1);
    chk("postrst_src2", s_a_source, 2'b10);
    tick();
    a_valid = 2'b00;

    // randomized traffic against a transaction-level model
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    out_m[0] = 0; out_m[1] = 0; mb_left[0] = 0; mb_left[1] = 0;
    last_g = 1; own = -1; a_rem = 0; d_on = 0; d_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (mb_left[i] == 0 && $urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 2);
          a_opcode[i]  = (r == 0) ? GET : ((r == 1) ? PUTF : PUTP);
          a_size[i]    = 4'($urandom_range(0, 5));
          a_source[i]  = 1'($urandom_range(0, 1));
          a_address[i] = $urandom;
          mb_left[i]   = (a_opcode[i] == GET) ? 1 : nbeats(int'(a_size[i]));
        end
        a_valid[i] = (mb_left[i] != 0) && ($urandom_range(0, 3) != 0);
        a_data[i]  = $urandom;
        a_mask[i]  = 4'($urandom);
        a_param[i] = 3'($urandom);
      end
      s_a_ready = ($urandom_range(0, 3) != 0);
      if (!d_on && q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rsp = q.pop_front();
        d_on = 1;
        d_left = (rsp.op == 3'd1) ? nbeats(int'(rsp.size)) : 1;
        s_d_source = rsp.src; s_d_opcode = rsp.op; s_d_size = rsp.size;
      end
      s_d_valid = d_on && ($urandom_range(0, 3) != 0);
      s_d_data = $urandom;
      d_ready = 2'($urandom);

      if (own >= 0) begin
        g = own; gany = 1;
      end else begin
        e0 = a_valid[0] && (out_m[0] < MAXO);
        e1 = a_valid[1] && (out_m[1] < MAXO);
        gany = e0 || e1;
        g = (e0 && e1) ? (1 - last_g) : (e1 ? 1 : 0);
      end
      exp_sav = gany && a_valid[g];
      didx = s_d_source[1];
      exp_sdr = d_ready[didx];

      #1;
      chk("rnd_m0_a_ready", m0_a_ready, gany && g == 0 && s_a_ready);
      chk("rnd_m1_a_ready", m1_a_ready, gany && g == 1 && s_a_ready);
      chk("rnd_s_a_valid", s_a_valid, exp_sav);
      if (exp_sav) begin
        chk("rnd_s_a_source", s_a_source, {g[0], a_source[g]});
        chk("rnd_s_a_address", s_a_address, a_address[g]);
        chk("rnd_s_a_data", s_a_data, a_data[g]);
      end
      chk("rnd_m0_d_valid", m0_d_valid, s_d_valid && !didx);
      chk("rnd_m1_d_valid", m1_d_valid, s_d_valid && didx);
      chk("rnd_s_d_ready", s_d_ready, exp_sdr);
      if (s_d_valid) begin
        chk("rnd_d_source", didx ? m1_d_source : m0_d_source, s_d_source[0]);
        chk("rnd_d_data", didx ? m1_d_data : m0_d_data, s_d_data);
      end

      a_hs = exp_sav && s_a_ready;
      d_hs = s_d_valid && exp_sdr;
      tick();

      if (a_hs) begin
        mb_left[g]--;
        if (own < 0) begin
          out_m[g]++;
          rsp.src = {g[0], a_source[g]};
          rsp.op = (a_opcode[g] == GET) ? 3'd1 : 3'd0;
          rsp.size = a_size[g];
          q.push_back(rsp);
          nb = nbeats(int'(a_size[g]));
          if (a_opcode[g] != GET && nb > 1) begin
            own = g; a_rem = nb - 1;
          end else begin
            last_g = g;
          end
        end else begin
          a_rem--;
          if (a_rem == 0) begin
            own = -1; last_g = g;
          end
        end
      end
      if (d_hs) begin
        d_left--;
        if (d_left == 0) begin
          d_on = 0;
          out_m[didx]--;
        end
      end
    end
    chk("rnd_no_unexpected", err_unexpected_d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tl_ul_arb2.md
TL_UL_ARB2 -- requirements
Module: tl_ul_arb2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; the beat holds 4 bytes.
REQ-003 SHALL have parameter SRC_W, default 1, master-side source width; the slave side uses SRC_W+1.
REQ-004 SHALL have parameter MAX_OUT, default 2, maximum outstanding requests per master (1..2^SRC_W).
REQ-005 SHALL have port clock, input, 1, the single clock; rising-edge.
REQ-006 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have ports m0_a_{valid,opcode[2:0],param[2:0],size[3:0],source[SRC_W],address[ADDR_W],mask[4],data[DATA_W]}, input, and m0_a_ready, output, forming master 0 channel A.
REQ-008 SHALL have the m1_a_* set, identical to m0_a_*, forming master 1 channel A.
REQ-009 SHALL have ports s_a_{valid,opcode,param,size,source[SRC_W+1],address,mask,data}, output, and s_a_ready, input, forming the slave channel A.
REQ-010 SHALL have ports s_d_{valid,opcode[2:0],param[1:0],size[3:0],source[SRC_W+1],denied,data}, input, and s_d_ready, output, forming the slave channel D.
REQ-011 SHALL have ports m0_d_* and m1_d_*, mirroring s_d_* with SRC_W source, with valid/fields as outputs and ready as an input.
REQ-012 SHALL have port err_unexpected_d, output, 1, sticky flag for a D response with no outstanding request.

Function
REQ-013 SHALL support TL-UL opcodes Get(4), PutFullData(0) and PutPartialData(1); beats(size) = 1 if size<=2, else 2^(size-2); sizes above 6 are illegal.
REQ-014 SHALL implement FSM states IDLE and LOCKED.
REQ-015 In IDLE, with exactly one eligible master valid, that master SHALL be granted combinationally.
REQ-016 In IDLE, with both eligible masters valid, the master != last_grant SHALL be granted (round-robin); last_grant resets to 1, so m0 wins first.
REQ-017 A master SHALL be eligible only when its outstanding count < MAX_OUT; an ineligible master SHALL see a_ready=0.
REQ-018 s_a_* SHALL equal the granted master's fields, with s_a_source = {grant_idx, master source}; the granted a_ready SHALL equal s_a_ready; the non-granted a_ready SHALL be 0. Latency is zero cycles.
REQ-019 On a first-beat handshake of a Put with beats>1, the block SHALL enter LOCKED, load beat_cnt = beats-1, and hold the grant.
REQ-020 In LOCKED, beat_cnt SHALL decrement on each handshake; a handshake at beat_cnt==1 is the last beat and SHALL return the FSM to IDLE.
REQ-021 last_grant SHALL update to grant_idx on the last-beat A handshake (single-beat requests are last beats).
REQ-022 outstanding[i] SHALL increment on the first-beat A handshake of master i.
REQ-023 D SHALL route by s_d_source[SRC_W]: the selected m*_d_valid = s_d_valid, its source = s_d_source[SRC_W-1:0], and s_d_ready = the selected m*_d_ready.
REQ-024 A D counter SHALL track AccessAckData (opcode 1) beats(size); AccessAck (opcode 0) is a single beat.
REQ-025 outstanding[idx] SHALL decrement on the D last-beat handshake.
REQ-026 On a simultaneous increment and decrement of the same master, the counter SHALL remain unchanged.
REQ-027 A D last beat with outstanding[idx]==0 SHALL set err_unexpected_d, leave the counter at 0, and still forward the beat.

Reset
REQ-028 While reset_n=0, the block SHALL hold: FSM=IDLE, last_grant=1, beat counters=0, outstanding=0, err_unexpected_d=0.
REQ-029 While reset_n=0, all a_ready and d_valid outputs SHALL be 0, regardless of inputs.
REQ-030 Reset asserted mid-burst SHALL abandon the burst immediately; no beats SHALL be replayed.

Structure
REQ-031 A shared package tl_ul_pkg SHALL hold the opcode constants, the FSM state enum and a beats-from-size function.
REQ-032 Sub-module tl_ul_rr_arb2 SHALL contain the round-robin pointer and grant logic; all else is flat.

Verification
REQ-033 Both masters issue Get size=2 simultaneously after reset -> m0 is granted on cycle 0 with s_a_source=0b00, and m1 follows with s_a_source=0b10.
REQ-034 m0 issues PutFull size=4 (4 beats) while m1 Get is pending -> 4 consecutive m0 beats, then m1; m1_a_ready=0 throughout.
REQ-035 m0 has 2 Gets unanswered (MAX_OUT=2) -> m0_a_ready=0 until a D AccessAck with source 0b00 completes; m0 is accepted the next cycle.
REQ-036 D AccessAckData size=3 with source 0b10 -> 2 beats on m1_d, m1_d_source=0; m1 backpressure stalls s_d_ready.
REQ-037 D response with source 0b00 and nothing outstanding -> err_unexpected_d=1 and stays 1 until reset.
REQ-038 reset_n pulsed low during beat 2 of a 4-beat Put -> FSM=IDLE, s_a_valid=0, counters=0; the next grant goes to m0.
